dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 256, SHALL give the number of 32-bit words stored.
REQ-002 Parameter LATENCY, default 2, SHALL give the wait cycles between request acceptance and the response; legal range is 0..15.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 req_valid  input  1  SHALL mean the initiator presents a request.
REQ-006 req_ready  output  1  SHALL mean the responder can accept a request this cycle.
REQ-007 req_we  input  1  SHALL select write (1) or read (0).
REQ-008 req_addr  input  32  SHALL be the byte address.
REQ-009 req_wdata  input  32  SHALL be the write data.
REQ-010 req_wstrb  input  4  SHALL be the per-byte write enables; bit i covers wdata[8i+7:8i].
REQ-011 rsp_valid  output  1  SHALL mean a response is presented.
REQ-012 rsp_ready  input  1  SHALL mean the initiator takes the response this cycle.
REQ-013 rsp_rdata  output  32  SHALL be the read data.
REQ-014 rsp_err  output  1  SHALL flag a misaligned or out-of-range access.

Function
REQ-015 The FSM SHALL have the states IDLE, WAIT and RESP; only one request SHALL be outstanding.
REQ-016 req_ready SHALL be 1 exactly in IDLE; a handshake is req_valid&&req_ready at a rising edge.
REQ-017 On a handshake, the address, we, wdata and wstrb SHALL be captured, and the state SHALL go to WAIT when LATENCY>0, otherwise to RESP.
REQ-018 In WAIT, a down-counter loaded with LATENCY-1 SHALL decrement each cycle; on 0 the state SHALL go to RESP.
REQ-019 rsp_valid SHALL be 1 exactly in RESP, first asserted LATENCY+1 cycles after the handshake edge.
REQ-020 rsp_valid, rsp_rdata and rsp_err SHALL hold stable while rsp_valid&&!rsp_ready.
REQ-021 On rsp_valid&&rsp_ready the state SHALL return to IDLE; req_ready SHALL be 1 in the next cycle; peak throughput is one access per LATENCY+2 cycles.
REQ-022 An error SHALL be raised when addr[1:0]!=0 or addr[31:2]>=DEPTH.
REQ-023 An erroring access SHALL not modify storage and SHALL respond with rsp_err=1 and rsp_rdata=0.
REQ-024 A legal write SHALL update only the strobed bytes, at the edge the state enters RESP, and SHALL respond with rsp_err=0 and rsp_rdata=0.
REQ-025 A write with wstrb=0 SHALL leave storage unchanged and still respond.
REQ-026 A legal read SHALL return the word at addr[31:2] as it stands on entry to RESP, so it reflects all earlier completed writes.
REQ-027 req_* inputs while req_ready=0 SHALL be ignored.

Reset
REQ-028 With reset high at an edge, the state SHALL become IDLE and the counter 0; rsp_valid, rsp_err and rsp_rdata SHALL be 0, and req_ready SHALL be 1 in the next cycle.
REQ-029 Reset during WAIT or RESP SHALL abandon the access; a pending write not yet committed SHALL not be applied.
REQ-030 Storage contents SHALL be unaffected by reset; they are undefined after power-up.
REQ-031 A request asserted in the same cycle as reset SHALL not be accepted.

Structure
REQ-032 Shared package riscv_mem_pkg SHALL hold: the state enum (IDLE/WAIT/RESP), DEPTH/LATENCY defaults, and a request struct (we, addr, wdata, wstrb).
REQ-033 Storage SHALL be a sub-module dmem_array: a DEPTH x 32 array with one port, a byte-enabled write and a combinational read.

Verification
REQ-034 LATENCY=2, write 0xDEADBEEF to 0x10 with wstrb=F, then read 0x10 -> each rsp_valid appears 3 cycles after its handshake; the read gives rdata=0xDEADBEEF, err=0.
REQ-035 Write 0x11223344 to 0x20 with wstrb=F, then 0xAABBCCDD with wstrb=4'b0101, then read -> 0x11BB33DD.
REQ-036 Read addr 0x13, and addr 4*DEPTH -> err=1, rdata=0; a following read of the targeted word shows no change.
REQ-037 Hold rsp_ready=0 for 5 cycles on a read -> rsp_valid/rdata stay stable and req_ready stays 0; the release is accepted and req_ready=1 in the next cycle.
REQ-038 Reset in WAIT of a write of 0x5555AAAA to 0x40 (previously 0) -> outputs go to 0, req_ready=1; a later read of 0x40 returns 0.
REQ-039 LATENCY=0, back-to-back reads with rsp_ready=1 -> rsp_valid one cycle after each handshake; handshakes every 2 cycles.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types and defaults for the data-memory responder: FSM states,
// parameter defaults and the captured request record.
package riscv_mem_pkg;

    localparam int unsigned DefaultDepth   = 256;
    localparam int unsigned DefaultLatency = 2;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with per-byte write enables and a combinational read.
// Contents are deliberately not reset.
module dmem_array #(
    parameter int unsigned Depth = 256,
    parameter int unsigned Aw    = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [Aw-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    input  logic [3:0]    wstrb_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [Depth];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder: one outstanding access, fixed wait latency,
// error response for misaligned or out-of-range addresses.
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int unsigned DEPTH   = DefaultDepth,
    parameter int unsigned LATENCY = DefaultLatency
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  CntLoad = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    mem_req_t    req_q, req_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    mem_req_t    cur_req;
    logic        cur_err;
    logic        enter_resp;
    logic        arr_we;
    logic [31:0] arr_rdata;

    // In IDLE the live request is used so a zero-latency access completes at its handshake.
    always_comb begin
        if (state_q == StIdle) begin
            cur_req.we    = req_we;
            cur_req.addr  = req_addr;
            cur_req.wdata = req_wdata;
            cur_req.wstrb = req_wstrb;
        end else begin
            cur_req = req_q;
        end
        cur_err = (cur_req.addr[1:0] != 2'b00) || ({2'b00, cur_req.addr[31:2]} >= DEPTH);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    req_d = cur_req;
                    if (LATENCY > 0) begin
                        state_d = StWait;
                        cnt_d   = CntLoad;
                    end else begin
                        enter_resp = 1'b1;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (enter_resp) begin
            state_d = StResp;
            err_d   = cur_err;
            rdata_d = (cur_err || cur_req.we) ? 32'h0 : arr_rdata;
        end
    end

    // A write still pending when reset arrives must never reach storage.
    assign arr_we = enter_resp && cur_req.we && !cur_err && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    dmem_array #(
        .Depth (DEPTH),
        .Aw    (AW)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .addr_i  (cur_req.addr[AW+1:2]),
        .wdata_i (cur_req.wdata),
        .wstrb_i (cur_req.wstrb),
        .rdata_o (arr_rdata)
    );

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance and a LATENCY=0 instance,
// with expected responses queued at issue time and compared on each response.
module tb_dmem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_wstrb;

    logic        z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
    logic [3:0]  z_req_wstrb;

    int npass  = 0;
    int ntotal = 0;

    exp_t        sb[$];
    logic [31:0] mdl[int];

    logic        z_we_t    [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] z_addr_t  [5] = '{32'h4, 32'h8, 32'h4, 32'h8, 32'h40};
    logic [31:0] z_wdata_t [5] = '{32'hA5A5A5A5, 32'h3C3C3C3C, 32'h0, 32'h0, 32'h0};

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH   (256),
        .LATENCY (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    dmem_responder #(
        .DEPTH   (16),
        .LATENCY (0)
    ) dut0 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (z_req_valid),
        .req_ready (z_req_ready),
        .req_we    (z_req_we),
        .req_addr  (z_req_addr),
        .req_wdata (z_req_wdata),
        .req_wstrb (z_req_wstrb),
        .rsp_valid (z_rsp_valid),
        .rsp_ready (z_rsp_ready),
        .rsp_rdata (z_rsp_rdata),
        .rsp_err   (z_rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic void model_push(input int sel, input int unsigned depth, input logic we,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       input logic [3:0] wstrb);
        exp_t        e;
        int          key;
        logic [31:0] w;
        key = sel * 65536 + int'(addr[17:2]);
        if (addr[1:0] != 2'b00 || addr[31:2] >= depth) begin
            e.rdata = 32'h0;
            e.err   = 1'b1;
        end else begin
            w = mdl.exists(key) ? mdl[key] : 32'h0;
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb[b]) w[8*b +: 8] = wdata[8*b +: 8];
                end
                mdl[key] = w;
                e.rdata  = 32'h0;
            end else begin
                e.rdata = w;
            end
            e.err = 1'b0;
        end
        sb.push_back(e);
    endfunction

    // Called at a negedge; returns at a negedge with the responder back in IDLE.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int hold, input string tag);
        exp_t        e;
        int          k;
        logic [31:0] rd0;
        model_push(0, 256, we, addr, wdata, wstrb);
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " req_ready"}, req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 1;
        while (!rsp_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " latency"}, k, 3);
        rd0 = rsp_rdata;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, " hold valid"}, rsp_valid, 1);
            chk({tag, " hold rdata"}, rsp_rdata, rd0);
            chk({tag, " hold req_ready"}, req_ready, 0);
        end
        e = sb.pop_front();
        chk({tag, " rdata"}, rsp_rdata, e.rdata);
        chk({tag, " err"}, rsp_err, e.err);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, " idle req_ready"}, req_ready, 1);
        chk({tag, " idle rsp_valid"}, rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        exp_t e;
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        req_wstrb   = 4'h0;
        rsp_ready   = 1'b0;
        z_req_valid = 1'b0;
        z_req_we    = 1'b0;
        z_req_addr  = 32'h0;
        z_req_wdata = 32'h0;
        z_req_wstrb = 4'hF;
        z_rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_err", rsp_err, 0);
        chk("reset rsp_rdata", rsp_rdata, 0);
        chk("reset req_ready", req_ready, 1);
        reset = 1'b0;
        @(negedge clk);

        access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "wr10");
        access(1'b0, 32'h10, 32'h0, 4'h0, 0, "rd10");

        access(1'b1, 32'h20, 32'h11223344, 4'hF, 0, "wr20");
        access(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, "wr20 strb");
        access(1'b0, 32'h20, 32'h0, 4'h0, 0, "rd20 merged");
        access(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, "wr20 nostrb");
        access(1'b0, 32'h20, 32'h0, 4'h0, 0, "rd20 after nostrb");

        access(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0, "wr00");
        access(1'b0, 32'h13, 32'h0, 4'h0, 0, "rd misaligned");
        access(1'b0, 32'h400, 32'h0, 4'h0, 0, "rd range");
        access(1'b1, 32'h12, 32'h0, 4'hF, 0, "wr misaligned");
        access(1'b1, 32'h400, 32'h01010101, 4'hF, 0, "wr range");
        access(1'b0, 32'h10, 32'h0, 4'h0, 0, "rd10 unchanged");
        access(1'b0, 32'h0, 32'h0, 4'h0, 0, "rd00 unchanged");

        access(1'b0, 32'h10, 32'h0, 4'h0, 5, "rd10 backpressure");

        // Abandon a write by resetting while it waits.
        access(1'b1, 32'h40, 32'h0, 4'hF, 0, "wr40 zero");
        req_we    = 1'b1;
        req_addr  = 32'h40;
        req_wdata = 32'h5555AAAA;
        req_wstrb = 4'hF;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("wait req_ready", req_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abandon rsp_valid", rsp_valid, 0);
        chk("abandon rsp_err", rsp_err, 0);
        chk("abandon rsp_rdata", rsp_rdata, 0);
        chk("abandon req_ready", req_ready, 1);
        repeat (4) @(negedge clk);
        chk("abandon no rsp", rsp_valid, 0);
        access(1'b0, 32'h40, 32'h0, 4'h0, 0, "rd40 after abandon");

        // A request coinciding with reset must be dropped.
        access(1'b1, 32'h44, 32'h12345678, 4'hF, 0, "wr44");
        reset     = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h44;
        req_wdata = 32'hFFFFFFFF;
        req_wstrb = 4'hF;
        req_valid = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("reset req dropped", rsp_valid, 0);
            @(negedge clk);
        end
        access(1'b0, 32'h44, 32'h0, 4'h0, 0, "rd44 unchanged");

        // Zero-latency instance, back to back with rsp_ready held high.
        z_rsp_ready = 1'b1;
        z_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            z_req_we    = z_we_t[i];
            z_req_addr  = z_addr_t[i];
            z_req_wdata = z_wdata_t[i];
            model_push(1, 16, z_we_t[i], z_addr_t[i], z_wdata_t[i], 4'hF);
            chk("z req_ready", z_req_ready, 1);
            @(negedge clk);
            chk("z rsp_valid", z_rsp_valid, 1);
            chk("z busy req_ready", z_req_ready, 0);
            e = sb.pop_front();
            chk("z rdata", z_rsp_rdata, e.rdata);
            chk("z err", z_rsp_err, e.err);
            @(negedge clk);
        end
        z_req_valid = 1'b0;
        chk("z final rsp_valid", z_rsp_valid, 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
